chi_link_ctrl: RTL and testbench
================================

# chi_link_ctrl

CHI link-layer controller for one TX/RX channel pair of the HN-F and RN-F bridges. Runs the CHI TX and RX link-activation state machines (STOP/ACTIVATE/RUN/DEACTIVATE) and keeps the L-credit books for both directions. Sits between the bridge channel datapath and the CHI pins. It gates flit transmission on held credits, issues RX credits from local buffer space, and drains credits on link teardown.

## Interface
- MAX_CREDITS, 15: maximum L-credits held or issued per direction (1..15)
- RX_BUF_DEPTH, 8: local RX flit buffer entries (1..15)

Ports:
- clk  in  1  bridge clock
- resetn  in  1  asynchronous, active-low reset
- link_up_req  in  1  software link enable from the register block; level-sensitive
- CHI_TXLINKACTIVEREQ  out  1  TX link request
- CHI_TXLINKACTIVEACK  in  1  TX link acknowledge from remote
- CHI_RXLINKACTIVEREQ  in  1  RX link request from remote
- CHI_RXLINKACTIVEACK  out  1  RX link acknowledge
- CHI_TXSACTIVE  out  1  high whenever the TX FSM is not in STOP
- tx_lcrdv  in  1  one credit received from the remote receiver
- tx_flit_req  in  1  datapath has a protocol flit ready
- tx_flit_gnt  out  1  flit may be sent this cycle (consumes one credit)
- tx_lcrd_return  out  1  send a credit-return link flit this cycle
- rx_lcrdv  out  1  one credit issued to the remote
- rx_flitv  in  1  protocol flit received (occupies a buffer entry)
- rx_lcrd_ret  in  1  credit-return link flit received (no buffer entry)
- rx_buf_pop  in  1  one buffer entry freed downstream
- tx_state, rx_state  out  2  FSM state: 00 STOP, 01 ACTIVATE, 10 RUN, 11 DEACTIVATE
- tx_credits, rx_outstanding  out  4  current credit counts
- credit_err  out  1  sticky protocol error (see Configuration)

## Operation
- TX FSM:
  - STOP→ACTIVATE when link_up_req=1 and rx_state≠DEACTIVATE.
  - ACTIVATE→RUN when TXLINKACTIVEACK=1.
  - RUN→DEACTIVATE when link_up_req=0.
  - DEACTIVATE→STOP when TXLINKACTIVEACK=0 and tx_credits=0.
- CHI_TXLINKACTIVEREQ=1 in ACTIVATE and RUN only.
- TX credit counting:
  - tx_credits increments on tx_lcrdv in ACTIVATE, RUN or DEACTIVATE. tx_lcrdv in STOP is ignored.
  - tx_flit_gnt = tx_flit_req & (tx_state==RUN) & (tx_credits≠0). This output is combinational; each grant decrements tx_credits.
  - In DEACTIVATE, tx_lcrd_return=1 on every cycle with tx_credits≠0, decrementing by 1. A simultaneous tx_lcrdv nets to zero change.
  - Increment and grant in the same cycle leave the count unchanged.
  - Increment at MAX_CREDITS saturates.
- RX FSM:
  - STOP→ACTIVATE when RXLINKACTIVEREQ=1.
  - ACTIVATE→RUN on the following cycle.
  - RUN→DEACTIVATE when RXLINKACTIVEREQ=0.
  - DEACTIVATE→STOP when rx_outstanding=0.
- CHI_RXLINKACTIVEACK=1 in RUN and DEACTIVATE.
- RX credit issue: in RUN, rx_lcrdv=1 (registered) when rx_outstanding+occupancy < RX_BUF_DEPTH and rx_outstanding < MAX_CREDITS, counting the same-cycle issue. No credits are issued outside RUN.
- RX counters:
  - rx_outstanding +1 per rx_lcrdv and −1 per rx_flitv or rx_lcrd_ret; rx_flitv and rx_lcrd_ret together give −2.
  - occupancy +1 per rx_flitv and −1 per rx_buf_pop.
  - The counters never go below 0; decrements at 0 are clamped.

## Timing
- Reset values: all outputs 0, both FSMs in STOP, all counters 0, credit_err 0. Reset is honoured mid-handshake; every counter clears.
- All outputs are registered except tx_flit_gnt.
- TXLINKACTIVEREQ rises 1 cycle after link_up_req rises.
- tx_flit_gnt is available on the cycle after the transition to RUN.
- RXLINKACTIVEACK rises 2 cycles after RXLINKACTIVEREQ.
- The first rx_lcrdv comes 1 cycle after RUN is entered; rx_lcrdv is issued at most 1 per cycle.
- A rx_buf_pop takes effect on the credit-issue decision in the next cycle.

## Configuration
- CHI_LINK_CTRL_CREDIT_ERR_EN defined: credit_err is set, and held until reset, on any of:
  - tx_lcrdv while tx_credits=MAX_CREDITS
  - tx_lcrdv in STOP
  - rx_flitv or rx_lcrd_ret while rx_outstanding=0
  - rx_flitv outside RUN/DEACTIVATE
- Undefined: credit_err is tied 0 and no checking logic is built. Saturation and clamping behaviour is unchanged.

## Test plan
- Link bring-up: raise link_up_req, ACK after 3 cycles, then 4 tx_lcrdv pulses → tx_state=10 and tx_credits=4. Four back-to-back tx_flit_req give 4 grants; the 5th request is not granted.
- Teardown with credits held: 3 credits held, drop link_up_req → REQ low next cycle, then 3 consecutive tx_lcrd_return pulses. Remote drops ACK → tx_state=00.
- RX credit issue with RX_BUF_DEPTH=8: RXLINKACTIVEREQ=1 → ACK after 2 cycles, then exactly 8 rx_lcrdv pulses and no more. 2 rx_flitv then 1 rx_buf_pop → exactly 1 further rx_lcrdv.
- RX teardown: rx_outstanding=5, REQ drops → no further rx_lcrdv; 5 rx_lcrd_ret → rx_state=00 and ACK=0.
- Simultaneous events: tx_lcrdv and a grant in the same cycle with tx_credits=2 → tx_credits stays 2.
- Error and reset cases:
  - With the macro defined, a 16th tx_lcrdv at MAX_CREDITS=15 → credit_err=1, tx_credits=15.
  - resetn asserted during ACTIVATE → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/chi_link_ctrl.sv
// ============================================================================
// chi_link_ctrl
// ----------------------------------------------------------------------------
// CHI link-layer controller for one TX/RX channel pair. It runs the TX and RX
// link-activation state machines (STOP / ACTIVATE / RUN / DEACTIVATE) and
// keeps the L-credit books in both directions:
//   - TX side: counts credits granted by the remote receiver, gates protocol
//     flits on held credits and hands all credits back on link teardown.
//   - RX side: issues credits to the remote transmitter while the local flit
//     buffer has room, and waits for all of them to come back before the RX
//     link is allowed to stop.
//
// Optional feature macro: CHI_LINK_CTRL_CREDIT_ERR_EN
//   defined   -> credit_err is a sticky flag raised on credit protocol misuse
//   undefined -> credit_err is tied low and no checking logic is built
//
// Parameters
//   MAX_CREDITS   maximum L-credits held or issued per direction (1..15)
//   RX_BUF_DEPTH  local RX flit buffer entries (1..15)
//
// Ports
//   clk                  bridge clock
//   resetn               asynchronous active-low reset
//   link_up_req          software link enable (level)
//   CHI_TXLINKACTIVEREQ  TX link request (ACTIVATE, RUN)
//   CHI_TXLINKACTIVEACK  TX link acknowledge from remote
//   CHI_RXLINKACTIVEREQ  RX link request from remote
//   CHI_RXLINKACTIVEACK  RX link acknowledge (RUN, DEACTIVATE)
//   CHI_TXSACTIVE        high whenever the TX FSM is not in STOP
//   tx_lcrdv             one credit received from the remote receiver
//   tx_flit_req          datapath has a protocol flit ready
//   tx_flit_gnt          flit may go this cycle (combinational, uses a credit)
//   tx_lcrd_return       credit-return link flit sent this cycle
//   rx_lcrdv             one credit issued to the remote
//   rx_flitv             protocol flit received (takes a buffer entry)
//   rx_lcrd_ret          credit-return link flit received (no buffer entry)
//   rx_buf_pop           one buffer entry freed downstream
//   tx_state, rx_state   FSM states: 00 STOP 01 ACTIVATE 10 RUN 11 DEACTIVATE
//   tx_credits           credits currently held for transmission
//   rx_outstanding       credits issued to the remote and not yet consumed
//   credit_err           sticky credit protocol error
// ============================================================================
module chi_link_ctrl #(
    parameter int MAX_CREDITS  = 15,
    parameter int RX_BUF_DEPTH = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       link_up_req,
    output logic       CHI_TXLINKACTIVEREQ,
    input  logic       CHI_TXLINKACTIVEACK,
    input  logic       CHI_RXLINKACTIVEREQ,
    output logic       CHI_RXLINKACTIVEACK,
    output logic       CHI_TXSACTIVE,
    input  logic       tx_lcrdv,
    input  logic       tx_flit_req,
    output logic       tx_flit_gnt,
    output logic       tx_lcrd_return,
    output logic       rx_lcrdv,
    input  logic       rx_flitv,
    input  logic       rx_lcrd_ret,
    input  logic       rx_buf_pop,
    output logic [1:0] tx_state,
    output logic [1:0] rx_state,
    output logic [3:0] tx_credits,
    output logic [3:0] rx_outstanding,
    output logic       credit_err
);

    // Encoding matches the values reported on tx_state / rx_state.
    typedef enum logic [1:0] {
        ST_STOP       = 2'b00,
        ST_ACTIVATE   = 2'b01,
        ST_RUN        = 2'b10,
        ST_DEACTIVATE = 2'b11
    } link_state_t;

    localparam logic [3:0] MAX_CRED  = 4'(MAX_CREDITS);
    localparam logic [4:0] BUF_DEPTH = 5'(RX_BUF_DEPTH);

    link_state_t tx_cur;
    link_state_t tx_nxt;
    link_state_t rx_cur;
    link_state_t rx_nxt;

    logic [3:0]  tx_credits_nxt;
    logic        tx_cred_inc;
    logic        tx_cred_dec;
    logic        tx_ret_now;

    logic [3:0]  rx_occupancy;
    logic [3:0]  rx_occ_nxt;
    logic [4:0]  rx_occ_sum;
    logic [4:0]  rx_occ_after_pop;
    logic [3:0]  rx_out_nxt;
    logic [4:0]  rx_out_sum;
    logic [4:0]  rx_out_diff;
    logic [1:0]  rx_dec;
    logic        rx_issue;

    assign tx_state = tx_cur;
    assign rx_state = rx_cur;

    // ------------------------------------------------------------------------
    // TX link FSM next state. The TX side may only start activating once the
    // RX side has finished any teardown in progress, and it may only return
    // to STOP after the remote has dropped ACK and every held credit has been
    // handed back through credit-return flits.
    // ------------------------------------------------------------------------
    always_comb begin
        tx_nxt = tx_cur;
        case (tx_cur)
            ST_STOP: begin
                if (link_up_req && (rx_cur != ST_DEACTIVATE))
                    tx_nxt = ST_ACTIVATE;
            end
            ST_ACTIVATE: begin
                if (CHI_TXLINKACTIVEACK)
                    tx_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!link_up_req)
                    tx_nxt = ST_DEACTIVATE;
            end
            ST_DEACTIVATE: begin
                if (!CHI_TXLINKACTIVEACK && (tx_credits == 4'd0))
                    tx_nxt = ST_STOP;
            end
            default: tx_nxt = ST_STOP;
        endcase
    end

    // ------------------------------------------------------------------------
    // TX credit book. Grants are combinational so the datapath can launch a
    // flit in the same cycle it asks. During DEACTIVATE every held credit is
    // returned, one per cycle. A received credit and a consumed credit in the
    // same cycle cancel out; a received credit at the ceiling is dropped.
    // ------------------------------------------------------------------------
    assign tx_flit_gnt = tx_flit_req && (tx_cur == ST_RUN) && (tx_credits != 4'd0);
    assign tx_ret_now  = (tx_cur == ST_DEACTIVATE) && (tx_credits != 4'd0);
    assign tx_cred_inc = tx_lcrdv && (tx_cur != ST_STOP);
    assign tx_cred_dec = tx_flit_gnt || tx_ret_now;

    always_comb begin
        tx_credits_nxt = tx_credits;
        if (tx_cred_inc && !tx_cred_dec) begin
            if (tx_credits != MAX_CRED)
                tx_credits_nxt = tx_credits + 4'd1;
        end else if (!tx_cred_inc && tx_cred_dec) begin
            tx_credits_nxt = tx_credits - 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // TX registers. The link pins and the credit-return strobe are registered
    // from the next state, so each one is a clean flop output that always
    // agrees with the state and credit count visible in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_cur              <= ST_STOP;
            tx_credits          <= 4'd0;
            CHI_TXLINKACTIVEREQ <= 1'b0;
            CHI_TXSACTIVE       <= 1'b0;
            tx_lcrd_return      <= 1'b0;
        end else begin
            tx_cur              <= tx_nxt;
            tx_credits          <= tx_credits_nxt;
            CHI_TXLINKACTIVEREQ <= (tx_nxt == ST_ACTIVATE) || (tx_nxt == ST_RUN);
            CHI_TXSACTIVE       <= (tx_nxt != ST_STOP);
            tx_lcrd_return      <= (tx_nxt == ST_DEACTIVATE) && (tx_credits_nxt != 4'd0);
        end
    end

    // ------------------------------------------------------------------------
    // RX link FSM next state. ACTIVATE lasts exactly one cycle; teardown waits
    // until the remote has consumed or returned every credit we issued.
    // ------------------------------------------------------------------------
    always_comb begin
        rx_nxt = rx_cur;
        case (rx_cur)
            ST_STOP: begin
                if (CHI_RXLINKACTIVEREQ)
                    rx_nxt = ST_ACTIVATE;
            end
            ST_ACTIVATE: begin
                rx_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!CHI_RXLINKACTIVEREQ)
                    rx_nxt = ST_DEACTIVATE;
            end
            ST_DEACTIVATE: begin
                if (rx_outstanding == 4'd0)
                    rx_nxt = ST_STOP;
            end
            default: rx_nxt = ST_STOP;
        endcase
    end

    // ------------------------------------------------------------------------
    // RX credit issue. A credit is only offered when every credit already in
    // flight plus every flit already buffered still leaves a free entry. The
    // outstanding count is bumped on the same edge the credit is launched, so
    // the following decision already accounts for it. Buffer pops and
    // returned credits therefore influence the decision one cycle later.
    // ------------------------------------------------------------------------
    assign rx_issue = (rx_cur == ST_RUN)
                   && (({1'b0, rx_outstanding} + {1'b0, rx_occupancy}) < BUF_DEPTH)
                   && (rx_outstanding < MAX_CRED);

    // ------------------------------------------------------------------------
    // RX outstanding count: +1 per issued credit, -1 per received flit and -1
    // per returned credit. A remote that sends more than it was given cannot
    // drive the count below zero.
    // ------------------------------------------------------------------------
    always_comb begin
        rx_out_sum  = {1'b0, rx_outstanding} + {4'd0, rx_issue};
        rx_dec      = {1'b0, rx_flitv} + {1'b0, rx_lcrd_ret};
        rx_out_diff = rx_out_sum - {3'd0, rx_dec};
        rx_out_nxt  = 4'd0;
        if (rx_out_sum >= {3'd0, rx_dec})
            rx_out_nxt = rx_out_diff[3:0];
    end

    // ------------------------------------------------------------------------
    // RX buffer occupancy: +1 per received flit, -1 per pop, held within the
    // 4-bit range so spurious pops or a flood of flits cannot wrap it.
    // ------------------------------------------------------------------------
    always_comb begin
        rx_occ_sum       = {1'b0, rx_occupancy} + {4'd0, rx_flitv};
        rx_occ_after_pop = rx_occ_sum;
        if (rx_buf_pop && (rx_occ_sum != 5'd0))
            rx_occ_after_pop = rx_occ_sum - 5'd1;
        rx_occ_nxt = rx_occ_after_pop[3:0];
        if (rx_occ_after_pop > 5'd15)
            rx_occ_nxt = 4'd15;
    end

    // ------------------------------------------------------------------------
    // RX registers. ACK follows the next state so it rises on the same edge
    // that RUN is entered, two cycles after the remote raises its request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_cur              <= ST_STOP;
            rx_outstanding      <= 4'd0;
            rx_occupancy        <= 4'd0;
            rx_lcrdv            <= 1'b0;
            CHI_RXLINKACTIVEACK <= 1'b0;
        end else begin
            rx_cur              <= rx_nxt;
            rx_outstanding      <= rx_out_nxt;
            rx_occupancy        <= rx_occ_nxt;
            rx_lcrdv            <= rx_issue;
            CHI_RXLINKACTIVEACK <= (rx_nxt == ST_RUN) || (rx_nxt == ST_DEACTIVATE);
        end
    end

`ifdef CHI_LINK_CTRL_CREDIT_ERR_EN
    logic err_event;

    // ------------------------------------------------------------------------
    // Credit protocol checking: a credit arriving when we already hold the
    // maximum or while the TX link is stopped, a flit or credit return when
    // nothing is outstanding, or a flit while the RX link is not accepting.
    // The flag stays set until reset so software can spot rare events.
    // ------------------------------------------------------------------------
    always_comb begin
        err_event = 1'b0;
        if (tx_lcrdv && (tx_credits == MAX_CRED))
            err_event = 1'b1;
        if (tx_lcrdv && (tx_cur == ST_STOP))
            err_event = 1'b1;
        if ((rx_flitv || rx_lcrd_ret) && (rx_outstanding == 4'd0))
            err_event = 1'b1;
        if (rx_flitv && (rx_cur != ST_RUN) && (rx_cur != ST_DEACTIVATE))
            err_event = 1'b1;
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            credit_err <= 1'b0;
        else if (err_event)
            credit_err <= 1'b1;
    end
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_chi_link_ctrl.sv
// ============================================================================
// tb_chi_link_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for chi_link_ctrl (MAX_CREDITS=15, RX_BUF_DEPTH=8).
// Directed scenarios cover bring-up, teardown, RX credit issue, simultaneous
// events, saturation and reset; a randomized run compares every output each
// cycle against a behavioural model of the link rules kept in this file.
// ============================================================================
module tb_chi_link_ctrl;

    localparam int MAXC  = 15;
    localparam int DEPTH = 8;
    localparam int S_STOP = 0, S_ACT = 1, S_RUN = 2, S_DEACT = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       link_up_req = 1'b0;
    logic       CHI_TXLINKACTIVEREQ;
    logic       CHI_TXLINKACTIVEACK = 1'b0;
    logic       CHI_RXLINKACTIVEREQ = 1'b0;
    logic       CHI_RXLINKACTIVEACK;
    logic       CHI_TXSACTIVE;
    logic       tx_lcrdv = 1'b0;
    logic       tx_flit_req = 1'b0;
    logic       tx_flit_gnt;
    logic       tx_lcrd_return;
    logic       rx_lcrdv;
    logic       rx_flitv = 1'b0;
    logic       rx_lcrd_ret = 1'b0;
    logic       rx_buf_pop = 1'b0;
    logic [1:0] tx_state;
    logic [1:0] rx_state;
    logic [3:0] tx_credits;
    logic [3:0] rx_outstanding;
    logic       credit_err;

    int checks = 0;
    int failures = 0;
    logic exp_err_sat;

    chi_link_ctrl #(.MAX_CREDITS(MAXC), .RX_BUF_DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .link_up_req         (link_up_req),
        .CHI_TXLINKACTIVEREQ (CHI_TXLINKACTIVEREQ),
        .CHI_TXLINKACTIVEACK (CHI_TXLINKACTIVEACK),
        .CHI_RXLINKACTIVEREQ (CHI_RXLINKACTIVEREQ),
        .CHI_RXLINKACTIVEACK (CHI_RXLINKACTIVEACK),
        .CHI_TXSACTIVE       (CHI_TXSACTIVE),
        .tx_lcrdv            (tx_lcrdv),
        .tx_flit_req         (tx_flit_req),
        .tx_flit_gnt         (tx_flit_gnt),
        .tx_lcrd_return      (tx_lcrd_return),
        .rx_lcrdv            (rx_lcrdv),
        .rx_flitv            (rx_flitv),
        .rx_lcrd_ret         (rx_lcrd_ret),
        .rx_buf_pop          (rx_buf_pop),
        .tx_state            (tx_state),
        .rx_state            (rx_state),
        .tx_credits          (tx_credits),
        .rx_outstanding      (rx_outstanding),
        .credit_err          (credit_err)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        link_up_req         = 1'b0;
        CHI_TXLINKACTIVEACK = 1'b0;
        CHI_RXLINKACTIVEREQ = 1'b0;
        tx_lcrdv            = 1'b0;
        tx_flit_req         = 1'b0;
        rx_flitv            = 1'b0;
        rx_lcrd_ret         = 1'b0;
        rx_buf_pop          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    // Everything must read zero while reset is held.
    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (2) tick();
        checks++; if (tx_state !== 2'b00) begin failures++; $display("[TB] FAIL reset_tx_state got=%b exp=00", tx_state); end
        checks++; if (rx_state !== 2'b00) begin failures++; $display("[TB] FAIL reset_rx_state got=%b exp=00", rx_state); end
        checks++; if (tx_credits !== 4'd0) begin failures++; $display("[TB] FAIL reset_tx_credits got=%0d exp=0", tx_credits); end
        checks++; if (rx_outstanding !== 4'd0) begin failures++; $display("[TB] FAIL reset_rx_out got=%0d exp=0", rx_outstanding); end
        checks++; if ({CHI_TXLINKACTIVEREQ, CHI_RXLINKACTIVEACK, CHI_TXSACTIVE} !== 3'b000) begin failures++; $display("[TB] FAIL reset_link_pins got=%b exp=000", {CHI_TXLINKACTIVEREQ, CHI_RXLINKACTIVEACK, CHI_TXSACTIVE}); end
        checks++; if ({tx_flit_gnt, tx_lcrd_return, rx_lcrdv, credit_err} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_strobes got=%b exp=0000", {tx_flit_gnt, tx_lcrd_return, rx_lcrdv, credit_err}); end
        resetn = 1'b1;
        tick();
    endtask

    // Bring the TX link up, collect 4 credits and spend them.
    task automatic test_tx_bringup();
        int grants;
        link_up_req = 1'b1;
        tick();
        checks++; if (CHI_TXLINKACTIVEREQ !== 1'b1) begin failures++; $display("[TB] FAIL tx_req_rise got=%b exp=1", CHI_TXLINKACTIVEREQ); end
        checks++; if (tx_state !== 2'b01) begin failures++; $display("[TB] FAIL tx_activate got=%b exp=01", tx_state); end
        repeat (2) tick();
        CHI_TXLINKACTIVEACK = 1'b1;
        tick();
        checks++; if (tx_state !== 2'b10) begin failures++; $display("[TB] FAIL tx_run got=%b exp=10", tx_state); end
        tx_lcrdv = 1'b1;
        repeat (4) tick();
        tx_lcrdv = 1'b0;
        checks++; if (tx_credits !== 4'd4) begin failures++; $display("[TB] FAIL tx_credits4 got=%0d exp=4", tx_credits); end
        grants = 0;
        tx_flit_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (tx_flit_gnt === 1'b1) grants++;
            if (i == 4) begin
                checks++; if (tx_flit_gnt !== 1'b0) begin failures++; $display("[TB] FAIL tx_fifth_grant got=%b exp=0", tx_flit_gnt); end
            end
            tick();
        end
        tx_flit_req = 1'b0;
        checks++; if (grants != 4) begin failures++; $display("[TB] FAIL tx_grant_count got=%0d exp=4", grants); end
        checks++; if (tx_credits !== 4'd0) begin failures++; $display("[TB] FAIL tx_credits_spent got=%0d exp=0", tx_credits); end
    endtask

    // Teardown while holding 3 credits: they drain as 3 return flits.
    task automatic test_tx_teardown();
        logic [5:0] seq;
        tx_lcrdv = 1'b1;
        repeat (3) tick();
        tx_lcrdv = 1'b0;
        checks++; if (tx_credits !== 4'd3) begin failures++; $display("[TB] FAIL td_credits3 got=%0d exp=3", tx_credits); end
        link_up_req = 1'b0;
        tick();
        checks++; if (CHI_TXLINKACTIVEREQ !== 1'b0) begin failures++; $display("[TB] FAIL td_req_fall got=%b exp=0", CHI_TXLINKACTIVEREQ); end
        checks++; if (tx_state !== 2'b11) begin failures++; $display("[TB] FAIL td_deact got=%b exp=11", tx_state); end
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            seq[i] = tx_lcrd_return;
            tick();
        end
        checks++; if (seq !== 6'b000111) begin failures++; $display("[TB] FAIL td_return_seq got=%b exp=000111", seq); end
        checks++; if (tx_state !== 2'b11) begin failures++; $display("[TB] FAIL td_hold_deact got=%b exp=11", tx_state); end
        CHI_TXLINKACTIVEACK = 1'b0;
        tick();
        checks++; if ({tx_state, CHI_TXSACTIVE} !== 3'b000) begin failures++; $display("[TB] FAIL td_stop got=%b exp=000", {tx_state, CHI_TXSACTIVE}); end
    endtask

    // Credit in and grant out in the same cycle, then saturation.
    task automatic test_simultaneous();
        link_up_req = 1'b1;
        tick();
        CHI_TXLINKACTIVEACK = 1'b1;
        tick();
        tx_lcrdv = 1'b1;
        repeat (2) tick();
        checks++; if (tx_credits !== 4'd2) begin failures++; $display("[TB] FAIL sim_pre got=%0d exp=2", tx_credits); end
        tx_flit_req = 1'b1;
        #1;
        checks++; if (tx_flit_gnt !== 1'b1) begin failures++; $display("[TB] FAIL sim_grant got=%b exp=1", tx_flit_gnt); end
        tick();
        tx_flit_req = 1'b0;
        checks++; if (tx_credits !== 4'd2) begin failures++; $display("[TB] FAIL sim_net_zero got=%0d exp=2", tx_credits); end
        checks++; if (credit_err !== 1'b0) begin failures++; $display("[TB] FAIL sim_no_err got=%b exp=0", credit_err); end
        // 13 more reach 15, the 14th arrives while already full.
        repeat (14) tick();
        tx_lcrdv = 1'b0;
`ifdef CHI_LINK_CTRL_CREDIT_ERR_EN
        exp_err_sat = 1'b1;
`else
        exp_err_sat = 1'b0;
`endif
        checks++; if (tx_credits !== 4'd15) begin failures++; $display("[TB] FAIL sat_credits got=%0d exp=15", tx_credits); end
        checks++; if (credit_err !== exp_err_sat) begin failures++; $display("[TB] FAIL sat_err got=%b exp=%b", credit_err, exp_err_sat); end
        do_reset();
    endtask

    // RX: 8 credits fill the buffer; one pop buys exactly one more.
    task automatic test_rx_credit_issue();
        int cnt;
        CHI_RXLINKACTIVEREQ = 1'b1;
        tick();
        checks++; if ({rx_state, CHI_RXLINKACTIVEACK} !== 3'b010) begin failures++; $display("[TB] FAIL rx_activate got=%b exp=010", {rx_state, CHI_RXLINKACTIVEACK}); end
        tick();
        checks++; if ({rx_state, CHI_RXLINKACTIVEACK, rx_lcrdv} !== 4'b1010) begin failures++; $display("[TB] FAIL rx_run_ack got=%b exp=1010", {rx_state, CHI_RXLINKACTIVEACK, rx_lcrdv}); end
        cnt = 0;
        repeat (12) begin tick(); if (rx_lcrdv === 1'b1) cnt++; end
        checks++; if (cnt != 8) begin failures++; $display("[TB] FAIL rx_issue_count got=%0d exp=8", cnt); end
        checks++; if (rx_outstanding !== 4'd8) begin failures++; $display("[TB] FAIL rx_out8 got=%0d exp=8", rx_outstanding); end
        cnt = 0;
        rx_flitv = 1'b1;
        repeat (2) begin tick(); if (rx_lcrdv === 1'b1) cnt++; end
        rx_flitv = 1'b0;
        rx_buf_pop = 1'b1;
        tick(); if (rx_lcrdv === 1'b1) cnt++;
        rx_buf_pop = 1'b0;
        repeat (5) begin tick(); if (rx_lcrdv === 1'b1) cnt++; end
        checks++; if (cnt != 1) begin failures++; $display("[TB] FAIL rx_pop_issue got=%0d exp=1", cnt); end
        checks++; if (rx_outstanding !== 4'd7) begin failures++; $display("[TB] FAIL rx_out7 got=%0d exp=7", rx_outstanding); end
    endtask

    // RX teardown with 5 outstanding credits returned as link flits.
    task automatic test_rx_teardown();
        int cnt;
        rx_flitv = 1'b1;
        repeat (2) tick();
        rx_flitv = 1'b0;
        checks++; if (rx_outstanding !== 4'd5) begin failures++; $display("[TB] FAIL rxtd_out5 got=%0d exp=5", rx_outstanding); end
        cnt = 0;
        CHI_RXLINKACTIVEREQ = 1'b0;
        tick(); if (rx_lcrdv === 1'b1) cnt++;
        checks++; if ({rx_state, CHI_RXLINKACTIVEACK} !== 3'b111) begin failures++; $display("[TB] FAIL rxtd_deact got=%b exp=111", {rx_state, CHI_RXLINKACTIVEACK}); end
        rx_lcrd_ret = 1'b1;
        repeat (5) begin tick(); if (rx_lcrdv === 1'b1) cnt++; end
        rx_lcrd_ret = 1'b0;
        checks++; if (rx_outstanding !== 4'd0) begin failures++; $display("[TB] FAIL rxtd_out0 got=%0d exp=0", rx_outstanding); end
        tick(); if (rx_lcrdv === 1'b1) cnt++;
        checks++; if ({rx_state, CHI_RXLINKACTIVEACK} !== 3'b000) begin failures++; $display("[TB] FAIL rxtd_stop got=%b exp=000", {rx_state, CHI_RXLINKACTIVEACK}); end
        checks++; if (cnt != 0) begin failures++; $display("[TB] FAIL rxtd_no_issue got=%0d exp=0", cnt); end
    endtask

    // Reset asserted in the middle of activation clears everything at once.
    task automatic test_reset_mid();
        link_up_req = 1'b1;
        CHI_RXLINKACTIVEREQ = 1'b1;
        tx_lcrdv = 1'b1;
        repeat (2) tick();
        checks++; if ({tx_state, tx_credits} !== 6'b01_0001) begin failures++; $display("[TB] FAIL mid_pre got=%b exp=010001", {tx_state, tx_credits}); end
        resetn = 1'b0;
        #1;
        checks++; if ({tx_state, rx_state, tx_credits, rx_outstanding} !== 12'd0) begin failures++; $display("[TB] FAIL mid_counters got=%h exp=0", {tx_state, rx_state, tx_credits, rx_outstanding}); end
        checks++; if ({CHI_TXLINKACTIVEREQ, CHI_RXLINKACTIVEACK, CHI_TXSACTIVE, tx_flit_gnt, tx_lcrd_return, rx_lcrdv, credit_err} !== 7'd0) begin failures++; $display("[TB] FAIL mid_outputs got=%b exp=0000000", {CHI_TXLINKACTIVEREQ, CHI_RXLINKACTIVEACK, CHI_TXSACTIVE, tx_flit_gnt, tx_lcrd_return, rx_lcrdv, credit_err}); end
        clear_inputs();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Random traffic against a behavioural model of the link rules.
    task automatic test_random();
        int mts, mtc, mrs, mro, mocc, mlv, merr;
        int ntc, nts, nrs, nro, nocc;
        logic m_gnt, m_ret, m_issue, m_inc, e_req, e_ack;
        do_reset();
        mts = S_STOP; mtc = 0; mrs = S_STOP; mro = 0; mocc = 0; mlv = 0; merr = 0;
        for (int cyc = 0; cyc < 1500 && failures < 30; cyc++) begin
            if ($urandom_range(19) == 0) link_up_req = ~link_up_req;
            if ($urandom_range(24) == 0) CHI_RXLINKACTIVEREQ = ~CHI_RXLINKACTIVEREQ;
            e_req = (mts == S_ACT) || (mts == S_RUN);
            if ($urandom_range(2) == 0) CHI_TXLINKACTIVEACK = e_req;
            tx_lcrdv    = ($urandom_range(2) == 0);
            tx_flit_req = ($urandom_range(1) == 0);
            rx_flitv    = ($urandom_range(3) == 0);
            rx_lcrd_ret = ($urandom_range(7) == 0);
            rx_buf_pop  = ($urandom_range(2) == 0);
            #1;
            m_gnt = tx_flit_req && (mts == S_RUN) && (mtc > 0);
            m_ret = (mts == S_DEACT) && (mtc > 0);
            e_ack = (mrs == S_RUN) || (mrs == S_DEACT);
            checks++; if (tx_state !== mts[1:0]) begin failures++; $display("[TB] FAIL rnd_tx_state cyc=%0d got=%0d exp=%0d", cyc, tx_state, mts); end
            checks++; if (rx_state !== mrs[1:0]) begin failures++; $display("[TB] FAIL rnd_rx_state cyc=%0d got=%0d exp=%0d", cyc, rx_state, mrs); end
            checks++; if (tx_credits !== mtc[3:0]) begin failures++; $display("[TB] FAIL rnd_tx_credits cyc=%0d got=%0d exp=%0d", cyc, tx_credits, mtc); end
            checks++; if (rx_outstanding !== mro[3:0]) begin failures++; $display("[TB] FAIL rnd_rx_out cyc=%0d got=%0d exp=%0d", cyc, rx_outstanding, mro); end
            checks++; if (tx_flit_gnt !== m_gnt) begin failures++; $display("[TB] FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, tx_flit_gnt, m_gnt); end
            checks++; if (tx_lcrd_return !== m_ret) begin failures++; $display("[TB] FAIL rnd_ret cyc=%0d got=%b exp=%b", cyc, tx_lcrd_return, m_ret); end
            checks++; if (rx_lcrdv !== mlv[0]) begin failures++; $display("[TB] FAIL rnd_lcrdv cyc=%0d got=%b exp=%0d", cyc, rx_lcrdv, mlv); end
            checks++; if ({CHI_TXLINKACTIVEREQ, CHI_TXSACTIVE} !== {e_req, (mts != S_STOP)}) begin failures++; $display("[TB] FAIL rnd_tx_pins cyc=%0d got=%b%b exp=%b%b", cyc, CHI_TXLINKACTIVEREQ, CHI_TXSACTIVE, e_req, (mts != S_STOP)); end
            checks++; if (CHI_RXLINKACTIVEACK !== e_ack) begin failures++; $display("[TB] FAIL rnd_rx_ack cyc=%0d got=%b exp=%b", cyc, CHI_RXLINKACTIVEACK, e_ack); end
            checks++; if (credit_err !== merr[0]) begin failures++; $display("[TB] FAIL rnd_err cyc=%0d got=%b exp=%0d", cyc, credit_err, merr); end

            // Model update for the coming edge.
            m_inc = tx_lcrdv && (mts != S_STOP);
            ntc = mtc + (m_inc ? 1 : 0) - ((m_gnt || m_ret) ? 1 : 0);
            if (ntc > MAXC) ntc = MAXC;
            nts = mts;
            if (mts == S_STOP && link_up_req && mrs != S_DEACT) nts = S_ACT;
            else if (mts == S_ACT && CHI_TXLINKACTIVEACK) nts = S_RUN;
            else if (mts == S_RUN && !link_up_req) nts = S_DEACT;
            else if (mts == S_DEACT && !CHI_TXLINKACTIVEACK && mtc == 0) nts = S_STOP;
            m_issue = (mrs == S_RUN) && (mro + mocc < DEPTH) && (mro < MAXC);
            nro = mro + (m_issue ? 1 : 0) - (rx_flitv ? 1 : 0) - (rx_lcrd_ret ? 1 : 0);
            if (nro < 0) nro = 0;
            nocc = mocc + (rx_flitv ? 1 : 0) - (rx_buf_pop ? 1 : 0);
            if (nocc < 0) nocc = 0;
            if (nocc > 15) nocc = 15;
            nrs = mrs;
            if (mrs == S_STOP && CHI_RXLINKACTIVEREQ) nrs = S_ACT;
            else if (mrs == S_ACT) nrs = S_RUN;
            else if (mrs == S_RUN && !CHI_RXLINKACTIVEREQ) nrs = S_DEACT;
            else if (mrs == S_DEACT && mro == 0) nrs = S_STOP;
`ifdef CHI_LINK_CTRL_CREDIT_ERR_EN
            if ((tx_lcrdv && (mtc == MAXC || mts == S_STOP)) ||
                ((rx_flitv || rx_lcrd_ret) && mro == 0) ||
                (rx_flitv && !(mrs == S_RUN || mrs == S_DEACT)))
                merr = 1;
`endif
            mts = nts; mtc = ntc; mrs = nrs; mro = nro; mocc = nocc;
            mlv = m_issue ? 1 : 0;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_tx_bringup();
        test_tx_teardown();
        test_simultaneous();
        test_rx_credit_issue();
        test_rx_teardown();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
